// File: rtl/spi_master_ctrl.sv
// spi_master_ctrl: SPI command initiator, serialises 10-bit commands on MOSI and captures read replies from MISO
module spi_master_ctrl #(
  parameter int RD_LATENCY  = 3,
  parameter int SS_HIGH_MIN = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid_i,
  input  logic [9:0] cmd_data_i,
  output logic       cmd_ready_o,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       busy_o,
  output logic       ss_n_o,
  output logic       mosi_o,
  input  logic       miso_i
);
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TURN, CAPTURE, GAP} state_t;
  localparam logic [3:0] TURN_LAST = 4'(RD_LATENCY > 0 ? RD_LATENCY - 1 : 0);
  localparam logic [3:0] GAP_LAST  = 4'(SS_HIGH_MIN - 1);
  state_t     state_q;
  logic [3:0] cnt_q;
  logic [9:0] sh_q;
  logic [7:0] rd_data_q;
  logic       rd_q, ss_n_q, mosi_q, rd_valid_q, ready_q, busy_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sh_q       <= 10'd0;
      rd_data_q  <= 8'd0;
      rd_q       <= 1'b0;
      ss_n_q     <= 1'b1;
      mosi_q     <= 1'b0;
      rd_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: if (cmd_valid_i) begin
          state_q <= LEAD;
          sh_q    <= cmd_data_i;
          rd_q    <= &cmd_data_i[9:8];
          ss_n_q  <= 1'b0;
          mosi_q  <= cmd_data_i[9];
          ready_q <= 1'b0;
          busy_q  <= 1'b1;
          cnt_q   <= 4'd0;
        end
        LEAD: begin
          state_q <= SHIFT;
          mosi_q  <= sh_q[9];
          sh_q    <= {sh_q[8:0], 1'b0};
        end
        SHIFT: if (cnt_q == 4'd9) begin
          cnt_q   <= 4'd0;
          mosi_q  <= 1'b0;
          ss_n_q  <= !rd_q;
          state_q <= !rd_q ? GAP : (RD_LATENCY == 0 ? CAPTURE : TURN);
        end else begin
          cnt_q  <= cnt_q + 4'd1;
          mosi_q <= sh_q[9];
          sh_q   <= {sh_q[8:0], 1'b0};
        end
        TURN: if (cnt_q == TURN_LAST) begin
          cnt_q   <= 4'd0;
          state_q <= CAPTURE;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        // shift register is reused to assemble the reply, MSB first
        CAPTURE: begin
          sh_q <= {sh_q[8:0], miso_i};
          if (cnt_q == 4'd7) begin
            rd_data_q  <= {sh_q[6:0], miso_i};
            rd_valid_q <= 1'b1;
            ss_n_q     <= 1'b1;
            cnt_q      <= 4'd0;
            state_q    <= GAP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        GAP: if (cnt_q == GAP_LAST) begin
          cnt_q   <= 4'd0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end else begin
          cnt_q <= cnt_q + 4'd1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign cmd_ready_o = ready_q;
  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign busy_o      = busy_q;
  assign ss_n_o      = ss_n_q;
  assign mosi_o      = mosi_q;
endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Single-clock SPI command initiator; the host side of the 10-bit command protocol (2-bit opcode + 8-bit payload) served by the SPI slave/RAM wrapper.
- Accepts one command word per handshake, serialises it MSB-first on MOSI under SS_n, and, for read-data commands, captures the 8-bit reply from MISO.
- Returns the reply to the local host with a one-cycle valid pulse.
- SPI lines are sampled and driven on clk; there is no separate SCLK.

Parameters:
- RD_LATENCY, 3: clk cycles between the last command bit and the first MISO data bit (range 0-15).
- SS_HIGH_MIN, 1: minimum clk cycles SS_n is held high between frames (range 1-15).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host presents a command.
- cmd_data  in  10  command word: [9:8] opcode (00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data), [7:0] payload.
- cmd_ready  out  1  block can accept a command; high only in IDLE.
- rd_data  out  8  byte captured from MISO.
- rd_valid  out  1  one-cycle pulse; rd_data is valid.
- busy  out  1  high whenever state is not IDLE.
- SS_n  out  1  slave select, active low.
- MOSI  out  1  serial data to slave.
- MISO  in  1  serial data from slave.

Behaviour:
- Reset, asynchronous: SS_n=1, MOSI=0, rd_valid=0, rd_data=0, cmd_ready=1, busy=0, state IDLE, counters and shift register cleared.
- Reset during a frame: SS_n returns high immediately, the frame is aborted, and no rd_valid is produced.
- States: IDLE, LEAD, SHIFT, TURN, CAPTURE, GAP.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, latch cmd_data into the shift register and go to LEAD. cmd_data is ignored outside IDLE.
- LEAD, 1 cycle: SS_n=0, MOSI=cmd[9] (opcode MSB, gives the slave its command-check cycle). Go to SHIFT.
- SHIFT, 10 cycles: SS_n=0, MOSI=cmd[9],cmd[8],...,cmd[0], one bit per cycle, 4-bit counter 0..9.
  - At count 9: if opcode==11, go to TURN, or to CAPTURE when RD_LATENCY==0.
  - Otherwise go to GAP.
- TURN, RD_LATENCY cycles: SS_n=0, MOSI=0. Go to CAPTURE.
- CAPTURE, 8 cycles: SS_n=0, MOSI=0. Sample MISO on each rising edge into a shift register, MSB first (first sample becomes rd_data[7]). After the 8th sample go to GAP.
- GAP, SS_HIGH_MIN cycles: SS_n=1, MOSI=0, cmd_ready=0. Go to IDLE.
- rd_valid: high for exactly the first GAP cycle after CAPTURE, with rd_data updated in the same cycle. rd_data holds its value until the next capture completes. Never asserted for opcodes 00/01/10.
- SS_n timing: goes low the cycle after acceptance and stays low continuously through the frame.
  - Low for 11 cycles for opcodes 00/01/10.
  - Low for 11+RD_LATENCY+8 cycles for opcode 11.
- Throughput:
  - Next acceptance earliest 11+SS_HIGH_MIN+1 cycles after the previous acceptance for non-read commands.
  - For reads, 11+RD_LATENCY+8+SS_HIGH_MIN+1 cycles.
- cmd_valid held high in IDLE is accepted back-to-back; GAP is always inserted between frames.
- All outputs are registered. SS_n and MOSI change only on clk rising edges.
- Counters saturate by design: no counter wraps mid-phase. A phase exits on its terminal count.

Test Plan:
- Reset mid-SHIFT of cmd 10'h1A5 -> SS_n=1 within the same cycle as rst_n low, no rd_valid, cmd_ready=1 after release.
- Write cmd 10'b01_1010_0011 -> SS_n low 11 cycles, MOSI sequence 0,0,1,1,0,1,0,0,0,1,1, no rd_valid, SS_n high 1 cycle, cmd_ready returns on cycle 13.
- Read cmd 10'b11_0000_0000 with a bench slave driving 8'hC3 on MISO from cycle 14 (RD_LATENCY=3) -> rd_data=8'hC3, one-cycle rd_valid, SS_n low exactly 22 cycles.
- Full sequence wr-addr 0x10, wr-data 0x5A, rd-addr 0x10, rd-data through the RAM wrapper -> rd_data=8'h5A, with SS_n high ≥SS_HIGH_MIN between each frame.
- cmd_valid held high with 3 queued commands -> exactly one acceptance per frame, cmd_ready low while busy, no dropped or duplicated frames.
- RD_LATENCY=0 and SS_HIGH_MIN=4 build, read with MISO=8'h81 -> capture starts the cycle after the last command bit, rd_data=8'h81, SS_n high 4 cycles.
